// File: rtl/debug_uart_rx_pkg.sv
// Shared types and constants for the debug UART receiver.
// Exports the FSM state encoding, synchroniser depth and 8N1 frame geometry.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_TICKS_PER_BIT = 1200;
    localparam int DEF_DATA_BITS     = 8;
    localparam int HALF_BIT          = DEF_TICKS_PER_BIT / 2;
    localparam int SYNC_STAGES       = 2;

    // start + data + stop
    localparam int FRAME_BITS = 1 + DEF_DATA_BITS + 1;

    function automatic int half_bit(input int ticks_per_bit);
        return ticks_per_bit / 2;
    endfunction

endpackage

// File: rtl/debug_uart_rx_if.sv
// Byte-stream handshake between the UART receiver and the command parser.
// The receiver drives through the master modport; the parser uses the slave modport.
interface debug_uart_rx_if
    import debug_uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;
    logic                 busy;

    modport master (
        output data_out,
        output data_valid,
        output framing_error,
        output overrun_error,
        output busy,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  overrun_error,
        input  busy,
        output data_ready
    );
endinterface

// File: rtl/debug_uart_rx_sync.sv
// Two-stage synchroniser for the raw serial line, with a registered previous value for edge detection.
// rx_prev is held low until the chain holds real samples, so a line low at reset release is not an edge.
module rx_synchronizer
    import debug_uart_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_prev
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             fill;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            fill    <= 2'd0;
            rx_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            if (fill != 2'(SYNC_STAGES)) begin
                fill <= fill + 2'd1;
            end else begin
                rx_prev <= rx_s;
            end
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver feeding the debugger command parser over a valid/ready handshake.
// Samples each bit at its midpoint using a tick counter; errors are reported as one-cycle pulses.
module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
    parameter int TICKS_WIDTH   = 12,
    parameter int DATA_BITS     = DEF_DATA_BITS
)(
    input  logic            clk_in,
    input  logic            reset,
    input  logic            rx_in,
    debug_uart_rx_if.master bus
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    localparam logic [TICKS_WIDTH-1:0] CNT_HALF_END = TICKS_WIDTH'(half_bit(TICKS_PER_BIT) - 1);
    localparam logic [TICKS_WIDTH-1:0] CNT_BIT_END  = TICKS_WIDTH'(TICKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST     = IDX_W'(DATA_BITS - 1);

    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;
    logic [1:0]             state;
    logic [TICKS_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   fe_q;
    logic                   oe_q;

    rx_synchronizer u_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .rx_in   (rx_in),
        .rx_s    (rx_s),
        .rx_prev (rx_prev)
    );

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            oe_q <= 1'b0;
            if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Leave at mid-stop-bit so a start bit half a bit later is still caught.
                    if (cnt == CNT_BIT_END) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rx_s) begin
                            fe_q <= 1'b1;
                        end else if (!valid_q || bus.data_ready) begin
                            data_q  <= shift_reg;
                            valid_q <= 1'b1;
                        end else begin
                            oe_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.data_out      = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = fe_q;
    assign bus.overrun_error = oe_q;
    assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed self-checking bench for debug_uart_rx at 16 ticks per bit.
// A negedge monitor collects accepted bytes and error-pulse cycle counts for the checks.
module tb_debug_uart_rx;
    localparam int TPB = 16;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    logic rx_in  = 1'b1;

    int tests_run  = 0;
    int tests_fail = 0;

    logic [7:0] rx_q[$];
    int valid_cycles = 0;
    int fe_cycles    = 0;
    int oe_cycles    = 0;
    logic busy_seen  = 1'b0;

    debug_uart_rx_if #(.DATA_BITS(8)) bus ();

    debug_uart_rx #(
        .TICKS_PER_BIT (TPB),
        .TICKS_WIDTH   (12),
        .DATA_BITS     (8)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .rx_in  (rx_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (bus.data_valid && bus.data_ready) rx_q.push_back(bus.data_out);
        if (bus.data_valid)    valid_cycles++;
        if (bus.framing_error) fe_cycles++;
        if (bus.overrun_error) oe_cycles++;
        if (bus.busy)          busy_seen = 1'b1;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk_in);
        rx_in = v;
        repeat (TPB - 1) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_in);
        #1 bus.data_ready = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_data"},  32'(bus.data_out), 32'h00);
        check_output({tag, "_valid"}, 32'(bus.data_valid), 32'h0);
        check_output({tag, "_fe"},    32'(bus.framing_error), 32'h0);
        check_output({tag, "_oe"},    32'(bus.overrun_error), 32'h0);
        check_output({tag, "_busy"},  32'(bus.busy), 32'h0);
    endtask

    int q_before;
    int v_before;
    int fe_before;
    int oe_before;

    initial begin
        bus.data_ready = 1'b1;
        repeat (5) @(negedge clk_in);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (10) @(negedge clk_in);

        // Single byte '0', consumer always ready
        v_before = valid_cycles;
        send_frame(8'h30, 1'b1);
        repeat (20) @(negedge clk_in);
        check_output("t1_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() >= 1) check_output("t1_byte", 32'(rx_q[0]), 32'h30);
        check_output("t1_valid_len", 32'(valid_cycles - v_before), 32'd1);
        check_output("t1_fe", 32'(fe_cycles), 32'd0);
        check_output("t1_oe", 32'(oe_cycles), 32'd0);

        // Back-to-back "-L" with no idle gap
        q_before = rx_q.size();
        send_frame(8'h2D, 1'b1);
        send_frame(8'h4C, 1'b1);
        repeat (20) @(negedge clk_in);
        check_output("t2_count", 32'(rx_q.size() - q_before), 32'd2);
        if (rx_q.size() >= q_before + 2) begin
            check_output("t2_first",  32'(rx_q[q_before]),     32'h2D);
            check_output("t2_second", 32'(rx_q[q_before + 1]), 32'h4C);
        end

        // Three-cycle glitch is a false start
        q_before  = rx_q.size();
        busy_seen = 1'b0;
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rx_in = 1'b1;
        repeat (30) @(negedge clk_in);
        check_output("t3_busy_seen", 32'(busy_seen), 32'd1);
        check_output("t3_busy_now", 32'(bus.busy), 32'd0);
        check_output("t3_no_byte", 32'(rx_q.size() - q_before), 32'd0);
        check_output("t3_no_err", 32'(fe_cycles + oe_cycles), 32'd0);

        // Framing error: 0x55 with low stop bit
        v_before = valid_cycles;
        send_frame(8'h55, 1'b0);
        @(negedge clk_in);
        rx_in = 1'b1;
        repeat (2 * TPB) @(negedge clk_in);
        check_output("t4_fe_len", 32'(fe_cycles), 32'd1);
        check_output("t4_no_valid", 32'(valid_cycles - v_before), 32'd0);
        check_output("t4_data_kept", 32'(bus.data_out), 32'h4C);
        check_output("t4_oe", 32'(oe_cycles), 32'd0);

        // Overrun: 'R' then 'r' while the consumer stalls
        set_ready(1'b0);
        q_before  = rx_q.size();
        fe_before = fe_cycles;
        send_frame(8'h52, 1'b1);
        send_frame(8'h72, 1'b1);
        repeat (20) @(negedge clk_in);
        check_output("t5_valid_held", 32'(bus.data_valid), 32'd1);
        check_output("t5_data_old", 32'(bus.data_out), 32'h52);
        check_output("t5_oe_len", 32'(oe_cycles), 32'd1);
        check_output("t5_fe", 32'(fe_cycles - fe_before), 32'd0);
        set_ready(1'b1);
        repeat (2) @(negedge clk_in);
        check_output("t5_accepted", 32'(rx_q.size() - q_before), 32'd1);
        if (rx_q.size() >= q_before + 1) check_output("t5_byte", 32'(rx_q[q_before]), 32'h52);
        check_output("t5_valid_drop", 32'(bus.data_valid), 32'd0);

        // Reset in the middle of data bit 4 of 0x62 (bit 4 is 0, so line is low at release)
        q_before  = rx_q.size();
        fe_before = fe_cycles;
        oe_before = oe_cycles;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h62 >> i));
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (TPB / 2) @(negedge clk_in);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (5) @(negedge clk_in);
        reset = 1'b1;
        repeat (10) @(negedge clk_in);
        check_output("t6_low_release_busy", 32'(bus.busy), 32'd0);
        rx_in = 1'b1;
        repeat (2 * TPB) @(negedge clk_in);
        check_output("t6_no_abort_byte", 32'(rx_q.size() - q_before), 32'd0);
        check_output("t6_no_err", 32'((fe_cycles - fe_before) + (oe_cycles - oe_before)), 32'd0);
        send_frame(8'h62, 1'b1);
        repeat (20) @(negedge clk_in);
        check_output("t6_resend_count", 32'(rx_q.size() - q_before), 32'd1);
        if (rx_q.size() >= q_before + 1) check_output("t6_resend_byte", 32'(rx_q[q_before]), 32'h62);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
